// File: rtl/k_fifo_pkg.sv
// Shared FIFO constants and pointer-width helper for the async FIFO blocks.
package k_fifo_pkg;
  localparam int DEF_ADDR_SIZE   = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEPTH           = 2**DEF_ADDR_SIZE;

  // Pointers carry one extra MSB to tell full from empty across wrap.
  function automatic int ptr_w(input int addr_size);
    return addr_size + 1;
  endfunction

  typedef logic [DEF_ADDR_SIZE:0] ptr_t;
endpackage

// File: rtl/k_g2b_converter_t1.sv
// Gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module k_g2b_converter_t1 #(
  parameter int size = 5
) (
  input  logic [size-1:0] gray,
  output logic [size-1:0] bin
);
  for (genvar i = 0; i < size; i++) begin : g_bit
    assign bin[i] = ^gray[size-1:i];
  end
endmodule

// File: rtl/k_wfull_sync_t1.sv
// Write-side FIFO status: read-pointer synchronizer, full, sticky overflow and,
// when K_WFULL_LEVEL_EN is defined, registered level / almost_full.
module k_wfull_sync_t1
  import k_fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AF_THRESH   = 2**ADDR_SIZE - 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_SIZE:0] wptr,
  input  logic [ADDR_SIZE:0] rptr_gray,
  input  logic               inc,
  output logic               full,
  output logic [ADDR_SIZE:0] level,
  output logic               almost_full,
  output logic               overflow
);
  localparam int PW = ptr_w(ADDR_SIZE);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("k_wfull_sync_t1: SYNC_STAGES must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > 2**ADDR_SIZE) begin : g_bad_af
    $error("k_wfull_sync_t1: AF_THRESH out of range 1..2**ADDR_SIZE");
  end

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  rq;

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
  end
  assign rq = sync_q[SYNC_STAGES-1];

  // Full when write is one lap ahead: top two gray bits inverted, rest equal.
  assign full = (wptr == {~rq[ADDR_SIZE:ADDR_SIZE-1], rq[ADDR_SIZE-2:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           overflow <= 1'b0;
    else if (inc && full) overflow <= 1'b1;
  end

`ifdef K_WFULL_LEVEL_EN
  localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);

  logic [PW-1:0] wbin, rbin, level_nxt;

  k_g2b_converter_t1 #(.size(PW)) u_g2b_w (.gray(wptr), .bin(wbin));
  k_g2b_converter_t1 #(.size(PW)) u_g2b_r (.gray(rq),   .bin(rbin));

  // Modulo subtraction absorbs pointer rollover.
  assign level_nxt = wbin - rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_nxt;
      almost_full <= (level_nxt >= AF_LIM);
    end
  end
`else
  assign level       = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_k_wfull_sync_t1.sv
// Directed bench for k_wfull_sync_t1 (ADDR_SIZE=4, SYNC_STAGES=2, AF_THRESH=14).
module tb_k_wfull_sync_t1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wptr, rptr_gray, level;
  logic       inc, full, almost_full, overflow;
  int         n_chk = 0;
  int         n_err = 0;
  int         wbin, rbin;

  k_wfull_sync_t1 #(.ADDR_SIZE(4), .SYNC_STAGES(2), .AF_THRESH(14)) dut (
    .clk(clk), .rst_n(rst_n), .wptr(wptr), .rptr_gray(rptr_gray), .inc(inc),
    .full(full), .level(level), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] g(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  // Expected level/almost_full depend on whether the level logic is built.
  function automatic logic [4:0] lv(input int v);
`ifdef K_WFULL_LEVEL_EN
    return v[4:0];
`else
    return (v == v) ? 5'd0 : 5'd0;
`endif
  endfunction

  function automatic logic af(input int v);
`ifdef K_WFULL_LEVEL_EN
    return v >= 14;
`else
    return (v == v) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wptr = '0; rptr_gray = '0; inc = 1'b0;
    #2;
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    tick(); rst_n = 1'b1;
    tick();

    // Fill 16 entries with the read pointer parked at 0.
    inc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      wptr = g(k);
      if (k == 16) inc = 1'b0;
      #1;
      chk($sformatf("fill_full_%0d", k), full, (k == 16));
      chk($sformatf("fill_level_%0d", k), level, lv(k - 1));
      chk($sformatf("fill_af_%0d", k), almost_full, af(k - 1));
    end
    tick(); #1;
    chk("full16_level", level, lv(16));
    chk("full16_af", almost_full, af(16));
    chk("full16_full", full, 1);
    chk("full16_ovf", overflow, 0);

    // One read frees an entry; full clears after two synchronizer edges.
    rptr_gray = g(1);
    tick(); #1;
    chk("rd1_full_e1", full, 1);
    tick(); #1;
    chk("rd1_full_e2", full, 0);
    chk("rd1_level_e2", level, lv(16));
    tick(); #1;
    chk("rd1_level_e3", level, lv(15));
    chk("rd1_af_e3", almost_full, af(15));

    // Refill to full, then hold inc one extra cycle to overflow.
    inc = 1'b1;
    tick();
    wptr = g(17);
    #1;
    chk("ovf_full", full, 1);
    chk("ovf_pre", overflow, 0);
    tick();
    inc = 1'b0;
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, lv(16));
    rptr_gray = g(5);
    tick(); tick(); tick(); #1;
    chk("ovf_sticky_a", overflow, 1);
    chk("ovf_rd_full", full, 0);
    chk("ovf_rd_level", level, lv(12));
    chk("ovf_rd_af", almost_full, af(12));
    rptr_gray = g(8);
    tick(); tick(); tick(); #1;
    chk("ovf_sticky_b", overflow, 1);
    chk("lvl9", level, lv(9));

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    rst_n = 1'b0; wptr = '0;
    #1;
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_full", full, 0);
    rptr_gray = '0;
    tick(); rst_n = 1'b1;
    tick();

    // Wrap-around: keep 4-5 outstanding across two pointer laps.
    wbin = 0; rbin = 0;
    inc = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(); wbin++; wptr = g(wbin);
    end
    inc = 1'b0;
    tick(); #1;
    chk("wrap_pre_level", level, lv(4));
    for (int j = 0; j < 40; j++) begin
      inc = 1'b1;
      tick(); wbin++; wptr = g(wbin); inc = 1'b0;
      #1;
      chk($sformatf("wrap_wfull_%0d", j), full, 0);
      tick(); #1;
      chk($sformatf("wrap_wlevel_%0d", j), level, lv(wbin - rbin));
      rbin++; rptr_gray = g(rbin);
      for (int s = 0; s < 3; s++) begin
        tick(); #1;
        chk($sformatf("wrap_rfull_%0d_%0d", j, s), full, 0);
      end
      chk($sformatf("wrap_rlevel_%0d", j), level, lv(wbin - rbin));
    end
    chk("wrap_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
